// File: rtl/mu0_mem_delay1_pkg.sv
// mu0_mem_pkg: shared constants and types for the MU0 memory subsystem.
// Address map: 0x000-0xFFD RAM, 0xFFE STATUS, 0xFFF OUTPORT.
package mu0_mem_pkg;

  typedef logic [15:0] mu0_word_t;

  localparam logic [11:0] ADDR_STATUS  = 12'hFFE;
  localparam logic [11:0] ADDR_OUTPORT = 12'hFFF;

  // STATUS word layout: {count[7:0], 6'b0, overflow, full}
  localparam int FULL      = 0;
  localparam int OVF       = 1;
  localparam int COUNT_LSB = 8;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_STATUS,
    REGION_OUTPORT
  } region_e;

  function automatic region_e decode_region(input logic [11:0] addr);
    region_e r;
    case (addr)
      ADDR_STATUS:  r = REGION_STATUS;
      ADDR_OUTPORT: r = REGION_OUTPORT;
      default:      r = REGION_RAM;
    endcase
    return r;
  endfunction

  function automatic mu0_word_t pack_status(input logic [7:0] count,
                                            input logic       ovf,
                                            input logic       full);
    mu0_word_t s;
    s                  = '0;
    s[COUNT_LSB +: 8]  = count;
    s[OVF]             = ovf;
    s[FULL]            = full;
    return s;
  endfunction

endpackage

// File: rtl/mu0_mem_delay1_if.sv
// CPU bus plus OUT-FIFO stream of the MU0 memory subsystem.
// master = CPU / consumer side, slave = memory subsystem.
interface mu0_mem_delay1_if;
  import mu0_mem_pkg::*;

  logic [11:0] address;
  logic        read;
  logic        write;
  mu0_word_t   writedata;
  mu0_word_t   readdata;
  logic        out_valid;
  mu0_word_t   out_data;
  logic        out_ready;
  logic        overflow;
  logic        prot_fault;

  modport master (
    output address, read, write, writedata, out_ready,
    input  readdata, out_valid, out_data, overflow, prot_fault
  );

  modport slave (
    input  address, read, write, writedata, out_ready,
    output readdata, out_valid, out_data, overflow, prot_fault
  );

endinterface

// File: rtl/mu0_mem_delay1_out_fifo.sv
// mu0_out_fifo: synchronous FIFO feeding the OUTPORT stream.
// No fall-through: a word pushed into an empty FIFO shows up as valid
// the cycle after the push. Push into a full FIFO is accepted only when
// a pop happens on the same edge.
module mu0_out_fifo
  import mu0_mem_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  mu0_word_t      push_data,
  input  logic           pop,
  output mu0_word_t      head,
  output logic           valid,
  output logic           full,
  output logic [PTR_W:0] count
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mu0_out_fifo: DEPTH must be a power of two and at least 2");
  end

  mu0_word_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; reset only discards the pointers.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mu0_mem_delay1.sv
// mu0_mem_delay1: 4096x16 RAM with one cycle of read latency, a STATUS
// register and an OUTPORT that pushes into a valid/ready OUT-FIFO.
// Optional build macro MU0_MEM_WPROT_EN: writes to RAM below PROT_TOP are
// dropped and raise the sticky prot_fault flag.
module mu0_mem_delay1
  import mu0_mem_pkg::*;
#(
  parameter           INIT_FILE  = "",
  parameter int       FIFO_DEPTH = 8,
  parameter logic [11:0] PROT_TOP = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  mu0_mem_delay1_if.slave   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef MU0_MEM_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  mu0_word_t        mem [4096];
  mu0_word_t        readdata_q;
  logic             overflow_q;
  logic             prot_fault_q;

  region_e          region;
  logic [12:0]      prot_diff;
  logic             below_prot;
  logic             ram_wr;
  logic             prot_hit;
  logic             status_wr;
  logic             push_req;
  logic             pop_req;
  logic             drop;
  logic             rd_only;

  mu0_word_t        fifo_head;
  logic             fifo_valid;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  assign region     = decode_region(bus.address);
  // Borrow bit of address - PROT_TOP flags addresses below the boundary.
  assign prot_diff  = {1'b0, bus.address} - {1'b0, PROT_TOP};
  assign below_prot = WPROT_EN && prot_diff[12];

  assign rd_only    = bus.read && !bus.write;
  assign ram_wr     = bus.write && (region == REGION_RAM) && !below_prot;
  assign prot_hit   = bus.write && (region == REGION_RAM) && below_prot;
  assign status_wr  = bus.write && (region == REGION_STATUS);
  assign push_req   = bus.write && (region == REGION_OUTPORT);
  assign pop_req    = fifo_valid && bus.out_ready;
  assign drop       = push_req && fifo_full && !pop_req;

  mu0_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (bus.writedata),
    .pop       (pop_req),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // RAM write port; an access coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst && ram_wr) mem[bus.address] <= bus.writedata;
  end

  // Registered read data; holds whenever no read-only access is present.
  always_ff @(posedge clk) begin
    if (!rst) begin
      readdata_q <= '0;
    end else if (rd_only) begin
      case (region)
        REGION_STATUS:  readdata_q <= pack_status(8'(fifo_count), overflow_q, fifo_full);
        REGION_OUTPORT: readdata_q <= '0;
        default:        readdata_q <= mem[bus.address];
      endcase
    end
  end

  // Sticky error flags, cleared by writing 1s to the STATUS address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q   <= 1'b0;
      prot_fault_q <= 1'b0;
    end else begin
      if (drop)                                 overflow_q <= 1'b1;
      else if (status_wr && bus.writedata[0])   overflow_q <= 1'b0;
      if (prot_hit)                             prot_fault_q <= 1'b1;
      else if (status_wr && bus.writedata[1])   prot_fault_q <= 1'b0;
    end
  end

  assign bus.readdata   = readdata_q;
  assign bus.out_valid  = fifo_valid;
  assign bus.out_data   = fifo_head;
  assign bus.overflow   = overflow_q;
  assign bus.prot_fault = WPROT_EN ? prot_fault_q : 1'b0;

endmodule

// File: tb/tb_mu0_mem_delay1.sv
// Directed bench for mu0_mem_delay1 (FIFO_DEPTH=8, PROT_TOP=0x100).
// Plain RAM traffic uses addresses at or above 0x100 so it behaves the
// same whether or not MU0_MEM_WPROT_EN is defined.
module tb_mu0_mem_delay1;
  import mu0_mem_pkg::*;

  localparam logic [11:0] RAM_A = 12'h210;
  localparam logic [11:0] RAM_B = 12'h211;
  localparam logic [11:0] RAM_C = 12'h220;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mu0_mem_delay1_if bus_if();

  mu0_mem_delay1 #(
    .INIT_FILE  (""),
    .FIFO_DEPTH (8),
    .PROT_TOP   (12'h100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    bus_if.address   = a;
    bus_if.writedata = d;
    bus_if.write     = 1'b1;
    bus_if.read      = 1'b0;
    tick();
    bus_if.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a);
    bus_if.address = a;
    bus_if.read    = 1'b1;
    bus_if.write   = 1'b0;
    tick();
    bus_if.read    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus_if.readdata !== 16'h0000) begin n_bad++; $display("FAIL reset_readdata: got %h want 0000", bus_if.readdata); end
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    n_cmp++; if (bus_if.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", bus_if.overflow); end
    n_cmp++; if (bus_if.prot_fault !== 1'b0) begin n_bad++; $display("FAIL reset_prot_fault: got %b want 0", bus_if.prot_fault); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram_rw();
    bus_write(RAM_A, 16'h1234);
    n_cmp++; if (bus_if.readdata !== 16'h0000) begin n_bad++; $display("FAIL ram_no_read_on_write: got %h want 0000", bus_if.readdata); end
    bus_read(RAM_A);
    n_cmp++; if (bus_if.readdata !== 16'h1234) begin n_bad++; $display("FAIL ram_read: got %h want 1234", bus_if.readdata); end
    bus_if.address = RAM_C;
    tick();
    tick();
    n_cmp++; if (bus_if.readdata !== 16'h1234) begin n_bad++; $display("FAIL ram_hold: got %h want 1234", bus_if.readdata); end
    bus_write(RAM_B, 16'hBEEF);
    // read+write together: write wins, readdata holds
    bus_if.address   = RAM_A;
    bus_if.writedata = 16'h4321;
    bus_if.read      = 1'b1;
    bus_if.write     = 1'b1;
    tick();
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    n_cmp++; if (bus_if.readdata !== 16'h1234) begin n_bad++; $display("FAIL rw_both_hold: got %h want 1234", bus_if.readdata); end
    bus_read(RAM_A);
    n_cmp++; if (bus_if.readdata !== 16'h4321) begin n_bad++; $display("FAIL rw_both_write: got %h want 4321", bus_if.readdata); end
    bus_read(RAM_B);
    n_cmp++; if (bus_if.readdata !== 16'hBEEF) begin n_bad++; $display("FAIL ram_read_b: got %h want beef", bus_if.readdata); end
  endtask

  task automatic test_fifo_order();
    bus_if.out_ready = 1'b0;
    bus_write(ADDR_OUTPORT, 16'hAAAA);
    n_cmp++; if (bus_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL push_latency_valid: got %b want 1", bus_if.out_valid); end
    bus_write(ADDR_OUTPORT, 16'hBBBB);
    n_cmp++; if (bus_if.out_data !== 16'hAAAA) begin n_bad++; $display("FAIL fifo_head_first: got %h want aaaa", bus_if.out_data); end
    bus_read(ADDR_OUTPORT);
    n_cmp++; if (bus_if.readdata !== 16'h0000) begin n_bad++; $display("FAIL outport_read: got %h want 0000", bus_if.readdata); end
    n_cmp++; if (bus_if.out_data !== 16'hAAAA) begin n_bad++; $display("FAIL fifo_head_stable: got %h want aaaa", bus_if.out_data); end
    bus_if.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus_if.out_data !== 16'hBBBB) begin n_bad++; $display("FAIL fifo_head_second: got %h want bbbb", bus_if.out_data); end
    n_cmp++; if (bus_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL fifo_valid_second: got %b want 1", bus_if.out_valid); end
    tick();
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL fifo_empty_after: got %b want 0", bus_if.out_valid); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    bus_if.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) bus_write(ADDR_OUTPORT, 16'(i));
    n_cmp++; if (bus_if.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", bus_if.overflow); end
    bus_read(ADDR_STATUS);
    n_cmp++; if (bus_if.readdata !== 16'h0803) begin n_bad++; $display("FAIL status_full_ovf: got %h want 0803", bus_if.readdata); end
    bus_write(ADDR_STATUS, 16'h0001);
    n_cmp++; if (bus_if.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", bus_if.overflow); end
    bus_read(ADDR_STATUS);
    n_cmp++; if (bus_if.readdata !== 16'h0801) begin n_bad++; $display("FAIL status_full: got %h want 0801", bus_if.readdata); end
    bus_if.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'(i)) begin n_bad++; $display("FAIL ovf_drain_%0d: got v=%b %h want v=1 %h", i, bus_if.out_valid, bus_if.out_data, 16'(i)); end
      tick();
    end
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_word9_dropped: got valid %b want 0", bus_if.out_valid); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    bus_if.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) bus_write(ADDR_OUTPORT, 16'h0100 + 16'(i));
    bus_if.address   = ADDR_OUTPORT;
    bus_if.writedata = 16'h5555;
    bus_if.write     = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.write     = 1'b0;
    bus_if.out_ready = 1'b0;
    n_cmp++; if (bus_if.overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_no_ovf: got %b want 0", bus_if.overflow); end
    n_cmp++; if (bus_if.out_data !== 16'h0102) begin n_bad++; $display("FAIL fpp_head: got %h want 0102", bus_if.out_data); end
    bus_read(ADDR_STATUS);
    n_cmp++; if (bus_if.readdata !== 16'h0801) begin n_bad++; $display("FAIL fpp_status: got %h want 0801", bus_if.readdata); end
    bus_if.out_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      n_cmp++; if (bus_if.out_data !== 16'h0100 + 16'(i)) begin n_bad++; $display("FAIL fpp_drain_%0d: got %h want %h", i, bus_if.out_data, 16'h0100 + 16'(i)); end
      tick();
    end
    n_cmp++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h5555) begin n_bad++; $display("FAIL fpp_last: got v=%b %h want v=1 5555", bus_if.out_valid, bus_if.out_data); end
    tick();
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty: got %b want 0", bus_if.out_valid); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_write(RAM_C, 16'hCAFE);
    bus_write(ADDR_OUTPORT, 16'h0011);
    bus_write(ADDR_OUTPORT, 16'h0022);
    bus_write(ADDR_OUTPORT, 16'h0033);
    bus_read(ADDR_STATUS);
    n_cmp++; if (bus_if.readdata !== 16'h0300) begin n_bad++; $display("FAIL pre_reset_status: got %h want 0300", bus_if.readdata); end
    // reset with a concurrent RAM write that must be discarded
    rst              = 1'b0;
    bus_if.address   = RAM_C;
    bus_if.writedata = 16'hDEAD;
    bus_if.write     = 1'b1;
    tick();
    rst              = 1'b1;
    bus_if.write     = 1'b0;
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", bus_if.out_valid); end
    n_cmp++; if (bus_if.readdata !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_readdata: got %h want 0000", bus_if.readdata); end
    bus_read(ADDR_STATUS);
    n_cmp++; if (bus_if.readdata !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_status: got %h want 0000", bus_if.readdata); end
    bus_read(RAM_C);
    n_cmp++; if (bus_if.readdata !== 16'hCAFE) begin n_bad++; $display("FAIL ram_survives_reset: got %h want cafe", bus_if.readdata); end
  endtask

  task automatic test_wprot();
    logic        exp_fault;
    logic        prot_on;
`ifdef MU0_MEM_WPROT_EN
    prot_on = 1'b1;
`else
    prot_on = 1'b0;
`endif
    exp_fault = prot_on;
    bus_write(12'h050, 16'h2222);
    n_cmp++; if (bus_if.prot_fault !== exp_fault) begin n_bad++; $display("FAIL wprot_fault: got %b want %b", bus_if.prot_fault, exp_fault); end
    bus_write(12'h100, 16'h3333);
    bus_read(12'h100);
    n_cmp++; if (bus_if.readdata !== 16'h3333) begin n_bad++; $display("FAIL wprot_boundary_write: got %h want 3333", bus_if.readdata); end
    bus_read(12'h050);
    if (prot_on) begin
      n_cmp++; if (bus_if.readdata === 16'h2222) begin n_bad++; $display("FAIL wprot_suppressed: got %h want anything but 2222", bus_if.readdata); end
    end else begin
      n_cmp++; if (bus_if.readdata !== 16'h2222) begin n_bad++; $display("FAIL wprot_off_write: got %h want 2222", bus_if.readdata); end
    end
    bus_write(ADDR_STATUS, 16'h0002);
    n_cmp++; if (bus_if.prot_fault !== 1'b0) begin n_bad++; $display("FAIL wprot_clear: got %b want 0", bus_if.prot_fault); end
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    rst              = 1'b0;
    bus_if.address   = '0;
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.writedata = '0;
    bus_if.out_ready = 1'b0;

    test_reset();
    test_ram_rw();
    test_fifo_order();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_wprot();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
